// File: rtl/uart_protocol_host.sv
// Bus-slave front end that turns local reads/writes into the ASCII UART command stream.
// Optional `UART_HOST_ADDR_CACHE_EN skips the address phase when the target's auto-increment already points there.
module uart_protocol_host #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cs,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_dat,
    output logic [7:0]  o_dat,
    output logic        o_ack,
    output logic        o_err,
    input  logic        i_uart_send_ready,
    output logic        o_uart_send_pulse,
    output logic [7:0]  o_uart_dat,
    input  logic        i_uart_received_pulse,
    input  logic [7:0]  i_uart_dat
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, SEND_L, SEND_ADDR, SEND_CMD, SEND_DATA, WAIT_RX, ACK
    } state_e;

    function automatic logic [7:0] hex_enc(input logic [3:0] n);
        hex_enc = (n < 4'd10) ? (8'd48 + {4'h0, n}) : (8'd87 + {4'h0, n});
    endfunction

    // Returns {valid, nibble}; only '0'-'9' and 'a'-'f' are accepted.
    function automatic logic [4:0] hex_dec(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)      hex_dec = {1'b1, c[3:0]};
        else if (c >= 8'h61 && c <= 8'h66) hex_dec = {1'b1, c[3:0] + 4'd9};
        else                               hex_dec = 5'b0;
    endfunction

    state_e        state_q, state_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    dat_q, dat_d;
    logic          we_q, we_d;
    logic [1:0]    nib_q, nib_d;
    logic [7:0]    rdat_q, rdat_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tx_pending;
    logic [7:0]    tx_char;
    logic [4:0]    rx_dec;
`ifdef UART_HOST_ADDR_CACHE_EN
    logic [15:0]   shadow_q, shadow_d;
    logic          shadow_vld_q, shadow_vld_d;
`endif

    assign rx_dec = hex_dec(i_uart_dat);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        nib_d      = nib_q;
        rdat_d     = rdat_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        tx_pending = 1'b0;
        tx_char    = 8'h00;
`ifdef UART_HOST_ADDR_CACHE_EN
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_cs) begin
                    addr_d  = i_addr;
                    dat_d   = i_dat;
                    we_d    = i_we;
                    nib_d   = 2'd0;
                    err_d   = 1'b0;
                    state_d = SEND_L;
`ifdef UART_HOST_ADDR_CACHE_EN
                    if (shadow_vld_q && i_addr == shadow_q) state_d = SEND_CMD;
`endif
                end
            end
            SEND_L: begin
                tx_pending = 1'b1;
                tx_char    = 8'h4C;
                if (i_uart_send_ready) state_d = SEND_ADDR;
            end
            SEND_ADDR: begin
                tx_pending = 1'b1;
                case (nib_q)
                    2'd0:    tx_char = hex_enc(addr_q[3:0]);
                    2'd1:    tx_char = hex_enc(addr_q[7:4]);
                    2'd2:    tx_char = hex_enc(addr_q[11:8]);
                    default: tx_char = hex_enc(addr_q[15:12]);
                endcase
                if (i_uart_send_ready) begin
                    nib_d = nib_q + 2'd1;
                    if (nib_q == 2'd3) state_d = SEND_CMD;
                end
            end
            SEND_CMD: begin
                tx_pending = 1'b1;
                tx_char    = we_q ? 8'h57 : 8'h52;
                if (i_uart_send_ready) begin
                    nib_d   = 2'd0;
                    tmo_d   = '0;
                    state_d = we_q ? SEND_DATA : WAIT_RX;
                end
            end
            SEND_DATA: begin
                tx_pending = 1'b1;
                tx_char    = hex_enc(nib_q[0] ? dat_q[7:4] : dat_q[3:0]);
                if (i_uart_send_ready) begin
                    nib_d = nib_q + 2'd1;
                    if (nib_q[0]) state_d = ACK;
                end
            end
            WAIT_RX: begin
                // A valid nibble in the same cycle as expiry takes priority over the timeout.
                if (i_uart_received_pulse && rx_dec[4]) begin
                    tmo_d = '0;
                    if (!nib_q[0]) begin
                        rdat_d[7:4] = rx_dec[3:0];
                        nib_d       = 2'd1;
                    end else begin
                        rdat_d[3:0] = rx_dec[3:0];
                        state_d     = ACK;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    rdat_d  = 8'hff;
                    err_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
`ifdef UART_HOST_ADDR_CACHE_EN
                shadow_d     = addr_q + 16'd1;
                shadow_vld_d = !err_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            nib_q   <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
`ifdef UART_HOST_ADDR_CACHE_EN
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            nib_q   <= nib_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
`ifdef UART_HOST_ADDR_CACHE_EN
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
`endif
        end
    end

    assign o_dat             = rdat_q;
    assign o_ack             = (state_q == ACK);
    assign o_err             = (state_q == ACK) && err_q;
    assign o_uart_send_pulse = tx_pending && i_uart_send_ready;
    assign o_uart_dat        = tx_char;
endmodule

// File: tb/tb_uart_protocol_host.sv
// Directed bench for uart_protocol_host; expectations follow `UART_HOST_ADDR_CACHE_EN when defined.
module tb_uart_protocol_host;
    logic        clk = 1'b0;
    logic        rst, cs, we, rdy, rx_p;
    logic [15:0] addr;
    logic [7:0]  wdat, rx_d;
    logic [7:0]  o_dat, o_uart_dat;
    logic        o_ack, o_err, o_pulse;

    always #5 clk = ~clk;

    uart_protocol_host #(.TIMEOUT_CYCLES(50)) dut (
        .i_clk                 (clk),
        .i_reset               (rst),
        .i_cs                  (cs),
        .i_we                  (we),
        .i_addr                (addr),
        .i_dat                 (wdat),
        .o_dat                 (o_dat),
        .o_ack                 (o_ack),
        .o_err                 (o_err),
        .i_uart_send_ready     (rdy),
        .o_uart_send_pulse     (o_pulse),
        .o_uart_dat            (o_uart_dat),
        .i_uart_received_pulse (rx_p),
        .i_uart_dat            (rx_d)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         acks  = 0;
    bit         rdy_mode = 1'b0;
    logic [7:0] txq[$];
    int         tcq[$];
    logic       a_ok, a_err;
    logic [7:0] a_dat;
    int         a_cyc, rx_cyc, base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Mode 1: ready high for one cycle out of every six.
    always @(posedge clk) begin
        #1;
        rdy = rdy_mode ? (cyc % 6 == 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (o_pulse) begin
            chk("pulse_rdy", rdy, 1'b1);
            txq.push_back(o_uart_dat);
            tcq.push_back(cyc);
        end
        if (o_ack) acks++;
        if (o_err) chk("err_with_ack", o_ack, 1'b1);
    end

    task automatic start_txn(input logic w, input logic [15:0] a, input logic [7:0] d);
        txq.delete();
        tcq.delete();
        @(posedge clk); #1;
        cs = 1'b1; we = w; addr = a; wdat = d;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 2000; i++) begin
            if (txq.size() >= n) break;
            @(negedge clk); #1;
        end
        if (txq.size() < n) chk("tx_wait", txq.size(), n);
    endtask

    task automatic wait_ack(input int budget);
        a_ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_ack) begin
                a_ok = 1'b1; a_dat = o_dat; a_err = o_err; a_cyc = cyc;
                break;
            end
        end
        chk("ack_seen", a_ok, 1'b1);
        @(posedge clk); #1;
        cs = 1'b0;
        if (a_ok) begin
            @(negedge clk);
            chk("ack_1cyc", o_ack, 1'b0);
        end
    endtask

    task automatic rx(input logic [7:0] c);
        @(posedge clk); #1;
        rx_p = 1'b1; rx_d = c; rx_cyc = cyc;
        @(posedge clk); #1;
        rx_p = 1'b0;
    endtask

    task automatic check_tx(input string tag, input string exp);
        chk({tag, "_len"}, txq.size(), exp.len());
        for (int i = 0; i < exp.len() && i < txq.size(); i++)
            chk(tag, txq[i], exp[i]);
    endtask

    initial begin
        string e;
        rst = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; wdat = '0;
        rx_p = 1'b0; rx_d = '0; rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", o_ack, 1'b0);
        chk("rst_err", o_err, 1'b0);
        chk("rst_pulse", o_pulse, 1'b0);
        chk("rst_dat", o_dat, 8'h00);
        chk("rst_udat", o_uart_dat, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;

        // Posted write, ready always high: eight back-to-back chars then ack.
        start_txn(1'b1, 16'h1a00, 8'h4d);
        wait_ack(200);
        check_tx("wr_tx", "L00a1Wd4");
        chk("wr_err", a_err, 1'b0);
        if (tcq.size() == 8) begin
            for (int i = 1; i < 8; i++) chk("wr_b2b", tcq[i] - tcq[0], i);
            chk("wr_ack_cyc", a_cyc - tcq[0], 8);
        end

        start_txn(1'b0, 16'h1234, 8'h00);
        wait_tx(6);
        rx("5"); rx("a");
        wait_ack(200);
        check_tx("rd_tx", "L4321R");
        chk("rd_dat", a_dat, 8'h5a);
        chk("rd_err", a_err, 1'b0);

        start_txn(1'b0, 16'h00ff, 8'h00);
        wait_tx(6);
        rx("5"); rx("X"); rx("a");
        wait_ack(200);
        check_tx("rdx_tx", "Lff00R");
        chk("rdx_dat", a_dat, 8'h5a);

        // Timeout: ack lands 50 edges after the edge that accepted '3'.
`ifdef UART_HOST_ADDR_CACHE_EN
        e = "R";
`else
        e = "L0010R";
`endif
        start_txn(1'b0, 16'h0100, 8'h00);
        wait_tx(e.len());
        rx("3");
        wait_ack(300);
        check_tx("to_tx", e);
        chk("to_cyc", a_cyc - rx_cyc, 51);
        chk("to_dat", a_dat, 8'hff);
        chk("to_err", a_err, 1'b1);

        rdy_mode = 1'b1;
        start_txn(1'b1, 16'h0101, 8'h3c);
        wait_ack(400);
        rdy_mode = 1'b0;
        check_tx("slow_tx", "L1010Wc3");
        if (tcq.size() == 8)
            for (int i = 1; i < 8; i++) chk("slow_gap", tcq[i] - tcq[i-1], 6);

        start_txn(1'b0, 16'hffff, 8'h00);
        wait_tx(6);
        rx("c"); rx("3");
        wait_ack(200);
        check_tx("wrap1_tx", "LffffR");
        chk("wrap1_dat", a_dat, 8'hc3);
`ifdef UART_HOST_ADDR_CACHE_EN
        e = "R";
`else
        e = "L0000R";
`endif
        start_txn(1'b0, 16'h0000, 8'h00);
        wait_tx(e.len());
        rx("0"); rx("7");
        wait_ack(200);
        check_tx("wrap2_tx", e);
        chk("wrap2_dat", a_dat, 8'h07);

        // Reset while the address nibbles are going out.
        start_txn(1'b1, 16'h5678, 8'h12);
        wait_tx(2);
        rst = 1'b1; cs = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_ack", o_ack, 1'b0);
        chk("mrst_pulse", o_pulse, 1'b0);
        chk("mrst_dat", o_dat, 8'h00);
        chk("mrst_udat", o_uart_dat, 8'h00);
        txq.delete(); tcq.delete();
        base = acks;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mrst_no_tx", txq.size(), 0);
        chk("mrst_no_ack", acks, base);
        start_txn(1'b1, 16'h1a00, 8'h4d);
        wait_ack(200);
        check_tx("post_rst_tx", "L00a1Wd4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_protocol_host.md
Name: uart_protocol_host

Overview:
- Host-side end of the ASCII UART memory-access protocol: a bus slave that turns each bus read/write into a command character stream for the remote UART target.
- Writes go out as "L" + 4 address nibbles + "W" + 2 data nibbles; reads as "L" + 4 address nibbles + "R", followed by the 2-nibble hex reply.
- Sits between a local bus master (CPU/test sequencer) and the UART TX/RX byte engines.
- Hex characters are lowercase; address and write-data nibbles are sent least-significant nibble first; read replies arrive most-significant nibble first.

Parameters:
TIMEOUT_CYCLES, 100000, clock cycles to wait for each reply character before aborting a read; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_cs  in  1  bus request; held with addr/dat/we stable until o_ack
i_we  in  1  1=write, 0=read
i_addr  in  16  bus address
i_dat  in  8  write data
o_dat  out  8  read data, valid in o_ack cycle (registered, holds until next read)
o_ack  out  1  one-cycle transaction-done pulse
o_err  out  1  one-cycle pulse coincident with o_ack on read timeout
i_uart_send_ready  in  1  TX engine accepts a byte this cycle
o_uart_send_pulse  out  1  byte strobe, only asserted when i_uart_send_ready=1
o_uart_dat  out  8  byte to send, valid with o_uart_send_pulse
i_uart_received_pulse  in  1  RX byte valid strobe
i_uart_dat  in  8  received byte

Behaviour:
- Reset: state=IDLE; o_ack=0, o_err=0, o_uart_send_pulse=0, o_dat=8'h00, o_uart_dat=8'h00; shadow address invalid; counters 0. Reset mid-transaction abandons it with no ack; the partial char stream is not completed.
- States: IDLE, SEND_L, SEND_ADDR, SEND_CMD, SEND_DATA, WAIT_RX, ACK.
- IDLE: if i_cs=1, latch addr/dat/we and go to SEND_L.
- SEND_L: send 'L' (8'h4C), then go to SEND_ADDR.
- SEND_ADDR: 2-bit nibble index 0..3 sends addr[3:0], [7:4], [11:8], [15:12], then go to SEND_CMD.
- SEND_CMD: sends 'W' (8'h57) and goes to SEND_DATA, or sends 'R' (8'h52) and goes to WAIT_RX.
- SEND_DATA: sends dat[3:0], then dat[7:4], then goes to ACK.
- WAIT_RX: accepts 2 hex chars. First received char -> o_dat[7:4], second -> [3:0], then go to ACK.
- ACK: o_ack=1 for exactly one cycle, then IDLE. The master drops i_cs the cycle after o_ack; a cs seen in IDLE after that starts a new transaction.
- Sending: a char is transferred in any cycle where the block has a char pending and i_uart_send_ready=1. That cycle has o_uart_send_pulse=1, and the state/index advances on that edge. Back-to-back chars are allowed when ready stays high. The pulse is never asserted while ready=0.
- Hex encode: nibble<10 -> 8'd48+n, else 8'd87+n (lowercase).
- Hex decode: '0'-'9', 'a'-'f' are valid. Any other received char is ignored and does not advance the nibble count. RX bytes outside WAIT_RX are ignored.
- Writes are posted: o_ack follows the last data char; the block does not wait for any remote response.
- Timeout: the counter clears on entering WAIT_RX and on each valid nibble. When it reaches TIMEOUT_CYCLES: o_dat=8'hff, go to ACK, assert o_err with o_ack, and invalidate the shadow address.
- Simultaneous events: an RX pulse and a timeout in the same cycle -> the nibble wins and the counter clears.
- Shadow address (used only by the optional feature): on a successful ack, shadow=latched addr+1, wrapping 16'hffff->16'h0000, and shadow valid=1.

Optional Feature:
UART_HOST_ADDR_CACHE_EN
- Defined: in IDLE, if shadow valid and i_addr==shadow, skip SEND_L/SEND_ADDR and go straight to SEND_CMD. This exploits the target's auto-increment.
- Undefined: every transaction sends "L"+4 nibbles. Shadow logic may be omitted.
- In both cases the first transaction after reset always sends L.

Test Plan:
- Write addr 16'h1a00, dat 8'h4d, ready held high -> TX chars "L","0","0","a","1","W","d","4" on 8 consecutive cycles; o_ack one cycle later; o_err=0.
- Read addr 16'h1234, RX replies "5","a" -> TX "L4321R"; o_dat=8'h5a with o_ack.
- Read with RX sequence "5","X","a" -> 'X' ignored; o_dat=8'h5a.
- Read where RX reply has "3" then no second char, with TIMEOUT_CYCLES=50 -> o_ack+o_err 50 cycles after "3", o_dat=8'hff; the next transaction sends L even with the cache enabled.
- Write with ready toggling (high 1 cycle, low 5 cycles) -> exactly one send pulse per ready-high cycle, same 8-char order, no pulse while ready=0.
- With UART_HOST_ADDR_CACHE_EN: read 16'hffff then read 16'h0000 -> second transaction sends only "R".
- Reset asserted mid-SEND_ADDR -> no further chars or ack; outputs 0; the next write sends the full L sequence.
